// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Holds the sweep FSM state encoding and default geometry.
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port: array data with same-cycle writeback bypass,
// busy masking by that writeback, and x0 / not-running forced to zero.
module regfile_sb_bypass #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            run,
  input  logic [AW-1:0]   rs_num,
  input  logic [XLEN-1:0] arr_data,
  input  logic            arr_busy,
  input  logic            we,
  input  logic [AW-1:0]   rd_num,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rs_data,
  output logic            rs_busy
);

  logic hit;

  assign hit = we && (rd_num == rs_num);

  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (run && (rs_num != '0)) begin
      rs_data = hit ? wdata : arr_data;
      rs_busy = arr_busy && !hit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-entry busy bits; a post-reset sweep zeroes
// one entry per cycle before the file reports ready.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0] rs_num,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  input  logic              we,
  input  logic [AW-1:0]     rd_num,
  input  logic [XLEN-1:0]   wdata,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic            run, clearing, wr_hit, is_hit;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;

  assign run      = (state_q == RUN) && !rst;
  assign clearing = (state_q == CLEAR) && !rst;
  assign wr_hit   = run && we && (rd_num != '0);
  assign is_hit   = run && issue_valid && (issue_rd != '0);
  assign ready    = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  // Sweep and writeback share the array's only write port.
  always_comb begin
    mem_we    = clearing || wr_hit;
    mem_addr  = clearing ? clr_idx_q : rd_num;
    mem_wdata = clearing ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Issue is applied last so it wins over a same-index writeback.
  always_comb begin
    busy_d = busy_q;
    if (clearing) busy_d[clr_idx_q] = 1'b0;
    if (wr_hit)   busy_d[rd_num]    = 1'b0;
    if (is_hit)   busy_d[issue_rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rs_num[i*AW +: AW];

    regfile_sb_bypass #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_byp (
      .run      (run),
      .rs_num   (idx),
      .arr_data (mem_q[idx]),
      .arr_busy (busy_q[idx]),
      .we       (we),
      .rd_num   (rd_num),
      .wdata    (wdata),
      .rs_data  (rs_data[i*XLEN +: XLEN]),
      .rs_busy  (rs_busy[i])
    );
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2.
REQ-003 SHALL have parameter NRD, default 2, read-port count, at least 1.
REQ-004 SHALL derive localparam AW = clog2(NREGS), the register index width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port ready  output  1  high when in RUN state.
REQ-008 SHALL have port rs_num  input  NRD*AW  packed read indices; port i uses bits [i*AW +: AW].
REQ-009 SHALL have port rs_data  output  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
REQ-010 SHALL have port rs_busy  output  NRD  per-port pending-write flag.
REQ-011 SHALL have port we  input  1  writeback enable.
REQ-012 SHALL have port rd_num  input  AW  writeback index.
REQ-013 SHALL have port wdata  input  XLEN  writeback data.
REQ-014 SHALL have port issue_valid  input  1  marks issue_rd as having a pending producer.
REQ-015 SHALL have port issue_rd  input  AW  index to mark busy.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR, then RUN.
REQ-017 In CLEAR, a counter clr_idx SHALL run from 0 to NREGS-1, zeroing one entry and its busy bit per cycle.
REQ-018 CLEAR SHALL go to RUN on the cycle after clr_idx = NREGS-1 is written, so ready rises exactly NREGS cycles after rst deasserts.
REQ-019 In CLEAR, we and issue_valid SHALL be ignored, rs_data SHALL read all-zero and rs_busy SHALL read all-zero.
REQ-020 Register 0 SHALL always read 0 and never be busy; writes and issues targeting index 0 SHALL be ignored.
REQ-021 Reads SHALL be combinational (0-cycle latency) from the array.
REQ-022 Each read port SHALL bypass independently: if we=1, rd_num = rs_num[i] and rd_num != 0, rs_data[i] SHALL equal the current wdata.
REQ-023 In RUN, with we=1 and rd_num != 0, entry rd_num SHALL take wdata at the clock edge and its busy bit SHALL clear.
REQ-024 In RUN, with issue_valid=1 and issue_rd != 0, busy[issue_rd] SHALL set at the clock edge.
REQ-025 If we and issue_valid target the same index in one cycle, data SHALL be written and busy SHALL end set (issue wins).
REQ-026 rs_busy[i] SHALL be busy[rs_num[i]] AND NOT (we and rd_num = rs_num[i]); same-cycle issue SHALL NOT affect rs_busy.
REQ-027 Duplicate indices across read ports SHALL return identical data and busy values.
REQ-028 Writeback to a non-busy register SHALL be legal: data is written and busy stays 0.

Reset
REQ-029 While rst=1: state SHALL be CLEAR, clr_idx SHALL be 0, and ready SHALL be 0.
REQ-030 rst asserted mid-RUN or mid-CLEAR SHALL restart the full NREGS-cycle clear; contents before reset SHALL NOT be observable afterwards.
REQ-031 The array SHALL be cleared only by the CLEAR sweep, not by a parallel reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and the default XLEN/NREGS constants.
REQ-033 There SHALL be one sub-module, regfile_sb_bypass: a single-port read mux with bypass and busy masking, instantiated NRD times in a generate loop.
REQ-034 Storage SHALL be a single-write-port array with no reset term, inferable as distributed RAM.

Verification
REQ-035 Reset with defaults: rst high 2 cycles then low -> ready=0 for exactly 32 cycles, then 1; all reads return 0.
REQ-036 Write x5=0xDEADBEEF while rs_num[0]=5 in the same cycle -> rs_data[0]=0xDEADBEEF that cycle and on every later cycle.
REQ-037 Write x0=0x12345678 and issue x0 -> x0 reads 0 and rs_busy for x0 is 0.
REQ-038 Issue x7, then write x7=0xA5 two cycles later -> rs_busy=1 in between; during the write cycle rs_busy=0 and rs_data=0xA5.
REQ-039 Issue x3 and write x3=0x55 in the same cycle -> next cycle x3 reads 0x55 with rs_busy=1.
REQ-040 rst pulse after writing x9=0xFF in RUN -> ready=0 for 32 cycles, then x9 reads 0 and is not busy.
